// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM row reader.
package sprite_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, EMIT} rd_state_t;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  // Counter width able to hold the full emitted length of one scaled row.
  function automatic int emit_len_w(input int width, input int scale_log2);
    return $clog2(width << scale_log2) + 1;
  endfunction

endpackage

// File: rtl/sprite_shift_unit.sv
// Row shift register with pixel-repeat and bit counters; done flags the last emit cycle.
module sprite_shift_unit
  import sprite_pkg::*;
#(
  parameter int WIDTH      = 96,
  parameter int SCALE_LOG2 = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] data,
  output logic             msb,
  output logic             done
);

  localparam int CNT_W = emit_len_w(WIDTH, SCALE_LOG2);
  localparam int REP_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'((1 << SCALE_LOG2) - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [REP_W-1:0] rep;
  logic [CNT_W-1:0] bcnt;
  logic             rep_tc;

  assign rep_tc = (rep == REP_LAST);
  assign msb    = shreg[WIDTH-1];
  assign done   = step && rep_tc && (bcnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      rep   <= '0;
      bcnt  <= '0;
    end else if (load) begin
      shreg <= data;
      rep   <= '0;
      bcnt  <= '0;
    end else if (step) begin
      if (rep_tc) begin
        rep   <= '0;
        shreg <= shreg << 1;
        bcnt  <= bcnt + 1'b1;
      end else begin
        rep <= rep + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_row_reader.sv
// Fetches one sprite ROM row per scanline and serialises it into pixel_on.
// Optional blink gating is enabled with the SPRITE_BLINK_EN macro.
module sprite_row_reader
  import sprite_pkg::*;
#(
  parameter int WIDTH        = 96,
  parameter int ROWS         = 16,
  parameter int ADDR_W       = 4,
  parameter int SCALE_LOG2   = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              line_start,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              pixel_on,
  output logic              busy
);

  localparam logic [10:0] SPAN = 11'(ROWS << SCALE_LOG2);

  rd_state_t   state;
  logic [9:0]  px;
  logic [10:0] dy;
  logic        hit;
  logic        x_match;
  logic        sh_load, sh_step, sh_msb, sh_done;
  logic        visible;

  // dy is a two's-complement difference; bit 10 set means the scan is above the logo.
  assign dy      = {1'b0, DrawY} - {1'b0, pos_y};
  assign hit     = enable && !dy[10] && (dy < SPAN);
  assign x_match = (DrawX == px);
  assign busy    = (state != IDLE);

  // The WAIT cycle that matches pos_x is itself the first emit cycle.
  assign sh_load = !line_start && (state == LOAD);
  assign sh_step = !line_start && ((state == WAIT && x_match) || state == EMIT);

  sprite_shift_unit #(.WIDTH(WIDTH), .SCALE_LOG2(SCALE_LOG2)) u_shift (
    .clk  (Clk),
    .rst_n(Reset_n),
    .load (sh_load),
    .step (sh_step),
    .data (rom_data),
    .msb  (sh_msb),
    .done (sh_done)
  );

`ifdef SPRITE_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);
  logic [BF_W-1:0] frame_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == BF_LAST) begin
        frame_cnt <= '0;
        visible   <= ~visible;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign visible = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      px       <= '0;
      pixel_on <= 1'b0;
    end else if (line_start) begin
      // A new scanline always wins, even in the middle of a row.
      pixel_on <= 1'b0;
      if (hit) begin
        state    <= FETCH;
        px       <= pos_x;
        rom_addr <= ADDR_W'(dy >> SCALE_LOG2);
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: pixel_on <= 1'b0;
        FETCH: begin
          pixel_on <= 1'b0;
          state    <= LOAD;
        end
        LOAD: begin
          pixel_on <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (x_match) begin
            pixel_on <= sh_msb && visible;
            state    <= sh_done ? IDLE : EMIT;
          end else begin
            pixel_on <= 1'b0;
            if (DrawX > px) state <= IDLE;
          end
        end
        EMIT: begin
          pixel_on <= sh_msb && visible;
          if (sh_done) state <= IDLE;
        end
        default: begin
          pixel_on <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_row_reader.sv
// Directed bench: two readers (scale 1x and 2x) share the scan inputs, each with its own ROM.
module tb_sprite_row_reader;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       line_start, frame_start, enable;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;

  logic [1:0] rom_addr0, rom_addr1;
  logic [7:0] rom_data0, rom_data1;
  logic       pixel_on0, pixel_on1, busy0, busy1;

  int checks = 0;
  int errors = 0;

`ifdef SPRITE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       lit0  [0:255];
  logic       lit1  [0:255];
  logic       bsy0  [0:255];
  logic       bsy1  [0:255];
  logic [1:0] addr0 [0:255];
  logic [1:0] addr1 [0:255];

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom(input logic [1:0] a);
    case (a)
      2'd0:    return 8'h0F;
      2'd1:    return 8'hF0;
      2'd2:    return 8'b1011_0001;
      default: return 8'h81;
    endcase
  endfunction

  assign rom_data0 = rom(rom_addr0);
  assign rom_data1 = rom(rom_addr1);

  sprite_row_reader #(.WIDTH(8), .ROWS(4), .ADDR_W(2), .SCALE_LOG2(0), .BLINK_FRAMES(2)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .pixel_on(pixel_on0), .busy(busy0));

  sprite_row_reader #(.WIDTH(8), .ROWS(4), .ADDR_W(2), .SCALE_LOG2(1), .BLINK_FRAMES(2)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .pixel_on(pixel_on1), .busy(busy1));

  // Index k holds outputs after the edge that closed the DrawX=k cycle.
  task automatic run_line(input logic [9:0] y, input int last_x);
    DrawY = y;
    line_start = 1'b1;
    for (int k = 0; k <= last_x; k++) begin
      DrawX = 10'(k);
      @(posedge Clk); #1;
      line_start = 1'b0;
      lit0[k] = pixel_on0;  lit1[k] = pixel_on1;
      bsy0[k] = busy0;      bsy1[k] = busy1;
      addr0[k] = rom_addr0; addr1[k] = rom_addr1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (pixel_on0 !== 1'b0 || busy0 !== 1'b0 || rom_addr0 !== 2'd0) begin
      errors++;
      $display("FAIL reset0: pix=%b busy=%b addr=%0d exp 0/0/0", pixel_on0, busy0, rom_addr0);
    end
    checks++;
    if (pixel_on1 !== 1'b0 || busy1 !== 1'b0 || rom_addr1 !== 2'd0) begin
      errors++;
      $display("FAIL reset1: pix=%b busy=%b addr=%0d exp 0/0/0", pixel_on1, busy1, rom_addr1);
    end
  endtask

  // Checks scale-1x row 2 (10110001) drawn at DrawX 100..107.
  task automatic check_row2_x1(input string tag);
    logic [7:0] r;
    r = 8'b1011_0001;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lit0[100+i] !== r[7-i]) begin
        errors++;
        $display("FAIL %s pix x=%0d: got %b exp %b", tag, 100+i, lit0[100+i], r[7-i]);
      end
    end
    checks++;
    if (lit0[99] !== 1'b0) begin
      errors++; $display("FAIL %s pre-start x=99: got %b exp 0", tag, lit0[99]);
    end
    for (int k = 108; k <= 130; k++) begin
      checks++;
      if (lit0[k] !== 1'b0) begin
        errors++; $display("FAIL %s post-row x=%0d: got %b exp 0", tag, k, lit0[k]);
      end
    end
  endtask

  task automatic test_basic();
    run_line(10'd52, 130);
    checks++;
    if (addr0[0] !== 2'd2 || bsy0[0] !== 1'b1) begin
      errors++; $display("FAIL basic fetch: addr=%0d busy=%b exp 2/1", addr0[0], bsy0[0]);
    end
    check_row2_x1("basic");
    checks++;
    if (bsy0[106] !== 1'b1 || bsy0[107] !== 1'b0) begin
      errors++; $display("FAIL basic busy drop: %b%b exp 10", bsy0[106], bsy0[107]);
    end
    // 2x reader sees dy=2 -> row 1 (11110000): lit 100..107 only.
    for (int k = 98; k <= 118; k++) begin
      checks++;
      if (lit1[k] !== ((k >= 100 && k <= 107) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL basic x2 row1 x=%0d: got %b", k, lit1[k]);
      end
    end
  endtask

  task automatic test_scale();
    logic [7:0] r;
    r = 8'b1011_0001;
    run_line(10'd54, 130);
    checks++;
    if (addr1[0] !== 2'd2) begin
      errors++; $display("FAIL scale fetch addr: got %0d exp 2", addr1[0]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (lit1[100+i] !== r[7-i/2]) begin
        errors++; $display("FAIL scale pix x=%0d: got %b exp %b", 100+i, lit1[100+i], r[7-i/2]);
      end
    end
    checks++;
    if (lit1[116] !== 1'b0 || bsy1[114] !== 1'b1 || bsy1[115] !== 1'b0) begin
      errors++;
      $display("FAIL scale end: pix116=%b busy114=%b busy115=%b exp 0/1/0", lit1[116], bsy1[114], bsy1[115]);
    end
    // Same line is out of range for the 1x reader (dy=4).
    for (int k = 0; k <= 130; k++) begin
      checks++;
      if (lit0[k] !== 1'b0 || bsy0[k] !== 1'b0) begin
        errors++; $display("FAIL range x1 y54 x=%0d: pix=%b busy=%b exp 0/0", k, lit0[k], bsy0[k]);
      end
    end
  endtask

  task automatic test_out_of_range();
    run_line(10'd49, 130);
    for (int k = 0; k <= 130; k++) begin
      checks++;
      if (lit0[k] !== 1'b0 || bsy0[k] !== 1'b0 || lit1[k] !== 1'b0 || bsy1[k] !== 1'b0) begin
        errors++; $display("FAIL range y49 x=%0d: pix=%b%b busy=%b%b exp 0", k, lit0[k], lit1[k], bsy0[k], bsy1[k]);
      end
    end
    enable = 1'b0;
    run_line(10'd52, 130);
    enable = 1'b1;
    for (int k = 0; k <= 130; k++) begin
      checks++;
      if (lit0[k] !== 1'b0 || bsy0[k] !== 1'b0) begin
        errors++; $display("FAIL disabled x=%0d: pix=%b busy=%b exp 0/0", k, lit0[k], bsy0[k]);
      end
    end
  endtask

  task automatic test_abort_missed();
    run_line(10'd52, 102);
    checks++;
    if (lit0[100] !== 1'b1 || lit0[101] !== 1'b0 || lit0[102] !== 1'b1) begin
      errors++; $display("FAIL abort pre: %b%b%b exp 101", lit0[100], lit0[101], lit0[102]);
    end
    // New line arrives while emitting; row 3 = 10000001.
    run_line(10'd53, 130);
    checks++;
    if (lit0[0] !== 1'b0 || bsy0[0] !== 1'b1 || addr0[0] !== 2'd3) begin
      errors++; $display("FAIL abort restart: pix=%b busy=%b addr=%0d exp 0/1/3", lit0[0], bsy0[0], addr0[0]);
    end
    for (int k = 99; k <= 110; k++) begin
      checks++;
      if (lit0[k] !== ((k == 100 || k == 107) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL abort row3 x=%0d: got %b", k, lit0[k]);
      end
    end
    pos_x = 10'd1;
    run_line(10'd52, 20);
    pos_x = 10'd100;
    checks++;
    if (bsy0[2] !== 1'b1 || bsy0[3] !== 1'b0) begin
      errors++; $display("FAIL missed busy: %b%b exp 10", bsy0[2], bsy0[3]);
    end
    for (int k = 0; k <= 20; k++) begin
      checks++;
      if (lit0[k] !== 1'b0) begin
        errors++; $display("FAIL missed pix x=%0d: got %b exp 0", k, lit0[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    run_line(10'd52, 103);
    checks++;
    if (lit0[103] !== 1'b1 || bsy0[103] !== 1'b1) begin
      errors++; $display("FAIL areset pre: pix=%b busy=%b exp 1/1", lit0[103], bsy0[103]);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (pixel_on0 !== 1'b0 || busy0 !== 1'b0 || rom_addr0 !== 2'd0) begin
      errors++; $display("FAIL areset: pix=%b busy=%b addr=%0d exp 0/0/0", pixel_on0, busy0, rom_addr0);
    end
    #1 Reset_n = 1'b1;
    run_line(10'd52, 130);
    check_row2_x1("after_reset");
  endtask

  task automatic test_blink();
    logic exp;
    for (int f = 0; f <= 4; f++) begin
      run_line(10'd52, 110);
      exp = BLINK ? ((f == 2 || f == 3) ? 1'b0 : 1'b1) : 1'b1;
      checks++;
      if (lit0[100] !== exp || lit0[103] !== exp) begin
        errors++; $display("FAIL blink frame %0d: pix100=%b pix103=%b exp %b", f, lit0[100], lit0[103], exp);
      end
      frame_start = 1'b1;
      DrawX = 10'd700;
      @(posedge Clk); #1;
      frame_start = 1'b0;
    end
  endtask

  initial begin
    Reset_n = 1'b0; line_start = 1'b0; frame_start = 1'b0; enable = 1'b1;
    DrawX = '0; DrawY = '0; pos_x = 10'd100; pos_y = 10'd50;
    #3;
    test_reset();
    #9 Reset_n = 1'b1;
    @(posedge Clk); #1;
    test_basic();
    test_scale();
    test_out_of_range();
    test_abort_missed();
    test_async_reset();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
